// File: rtl/cpu_boot_sequencer_pkg.sv
// Shared definitions for the mini_cpu boot sequencer: FSM state encoding and
// instruction word geometry used to turn a word index into a byte address.
package cpu_boot_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } boot_state_e;

endpackage

// File: rtl/cpu_boot_sequencer_run_counter.sv
// Run-window counter for the boot sequencer.
// Counts enabled cycles from zero and flags the last cycle of a window of
// 'limit' cycles. A limit of zero means an unbounded window, so the flag
// never fires.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : force count to zero (takes priority over enable)
//   enable      : count this cycle
//   limit       : window length in cycles
//   terminal_c  : combinational, high on the final enabled cycle of the window
module cpu_boot_sequencer_run_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal_c
);

  logic [CNT_W-1:0] count_q;

  // Up-counter, restarted whenever the window is not active
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign terminal_c = enable && (limit != '0) && (count_q == limit - CNT_W'(1));

endmodule

// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer for mini_cpu: streams a program into instruction memory over
// the CPU load port, then releases the CPU from reset and enables fetch and
// register writes for a bounded (or open-ended) run window.
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin load+run (IDLE/HALT only) / return to IDLE
//   prog_len, base_addr,
//   run_cycles          : job parameters, latched on an accepted start
//   s_valid, s_data,
//   s_ready             : program word stream (valid/ready)
//   cpu_reset, load_*,
//   fetch_enable,
//   reg_write_enable,
//   base_pc             : mini_cpu control pins
//   busy, done          : status (LOAD/START/RUN, HALT)
module cpu_boot_sequencer
  import cpu_boot_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              cpu_reset,
  output logic              load_enable,
  output logic [ADDR_W-1:0] load_address,
  output logic [DATA_W-1:0] load_data,
  output logic              fetch_enable,
  output logic              reg_write_enable,
  output logic [ADDR_W-1:0] base_pc,
  output logic              busy,
  output logic              done
);

  boot_state_e      state_q;
  boot_state_e      state_c;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [CNT_W-1:0] run_q;

  logic start_ok_c;
  logic hs_c;
  logic write_c;
  logic last_c;
  logic run_done_c;

  logic s_ready_d;
  logic cpu_reset_d;
  logic fetch_d;
  logic busy_d;
  logic done_d;

  assign start_ok_c = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign hs_c       = (state_q == ST_LOAD) && s_valid && s_ready;
  // An abort in the same cycle as a handshake drops that word
  assign write_c    = hs_c && !abort;
  assign last_c     = (idx_q == len_q - LEN_W'(1));

  cpu_boot_sequencer_run_counter #(
    .CNT_W (CNT_W)
  ) u_run_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q != ST_RUN),
    .enable     (state_q == ST_RUN),
    .limit      (run_q),
    .terminal_c (run_done_c)
  );

  // Next state and next values of the state-decoded outputs
  always_comb begin
    state_c     = state_q;
    s_ready_d   = 1'b0;
    cpu_reset_d = 1'b1;
    fetch_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok_c) begin
          state_c = (prog_len != '0) ? ST_LOAD : ST_START;
        end
      end
      ST_LOAD: begin
        if (hs_c && last_c) begin
          state_c = ST_START;
        end
      end
      ST_START: state_c = ST_RUN;
      ST_RUN: begin
        if (run_done_c) begin
          state_c = ST_HALT;
        end
      end
      default: state_c = ST_IDLE;
    endcase

    if (abort) begin
      state_c = ST_IDLE;
    end

    // Outputs follow the state being entered so they are valid from its first cycle
    s_ready_d   = (state_c == ST_LOAD);
    cpu_reset_d = (state_c == ST_IDLE) || (state_c == ST_LOAD);
    fetch_d     = (state_c == ST_RUN);
    busy_d      = (state_c == ST_LOAD) || (state_c == ST_START) || (state_c == ST_RUN);
    done_d      = (state_c == ST_HALT);
  end

  // State register and state-decoded output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      s_ready          <= 1'b0;
      cpu_reset        <= 1'b1;
      fetch_enable     <= 1'b0;
      reg_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_c;
      s_ready          <= s_ready_d;
      cpu_reset        <= cpu_reset_d;
      fetch_enable     <= fetch_d;
      reg_write_enable <= fetch_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  // Job parameters, word index and the imem write port
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      run_q        <= '0;
      base_pc      <= '0;
      load_enable  <= 1'b0;
      load_address <= '0;
      load_data    <= '0;
    end else begin
      load_enable <= write_c;
      if (start_ok_c) begin
        len_q   <= prog_len;
        idx_q   <= '0;
        run_q   <= run_cycles;
        base_pc <= base_addr;
      end else if (write_c) begin
        idx_q        <= idx_q + LEN_W'(1);
        load_address <= base_pc + (ADDR_W'(idx_q) << WORD_SHIFT);
        load_data    <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
module tb_cpu_boot_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  prog_len;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  run_cycles;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              cpu_reset;
  logic              load_enable;
  logic [ADDR_W-1:0] load_address;
  logic [DATA_W-1:0] load_data;
  logic              fetch_enable;
  logic              reg_write_enable;
  logic [ADDR_W-1:0] base_pc;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  cpu_boot_sequencer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .prog_len         (prog_len),
    .base_addr        (base_addr),
    .run_cycles       (run_cycles),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .cpu_reset        (cpu_reset),
    .load_enable      (load_enable),
    .load_address     (load_address),
    .load_data        (load_data),
    .fetch_enable     (fetch_enable),
    .reg_write_enable (reg_write_enable),
    .base_pc          (base_pc),
    .busy             (busy),
    .done             (done)
  );

  int total  = 0;
  int passed = 0;

  // Observed imem writes (address, data, cycle stamp)
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int unsigned       wc_q[$];
  int unsigned       cyc = 0;

  // Program words for the next job
  logic [DATA_W-1:0] tx_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_enable === 1'b1) begin
      wa_q.push_back(load_address);
      wd_q.push_back(load_data);
      wc_q.push_back(cyc);
    end
  end

  // Full job: start, stream tx_words, check START, run window and HALT, then
  // compare the write log against base + 4*i (mod 2^32) with the sent words.
  task automatic run_program(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] runc,
                             input logic [15:0] pat, input bit use_pat, input int pct,
                             input bit poke, input string tag);
    int unsigned len, i, k, guard, n, bad_track, err, nchk;
    logic [ADDR_W-1:0] ea;
    len = tx_words.size();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    @(negedge clk);
    start = 1'b1; prog_len = LEN_W'(len); base_addr = base; run_cycles = runc;
    @(negedge clk);
    start = 1'b0;
    if (len != 0) begin
      total++;
      if (cpu_reset !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || s_ready !== 1'b1)
        $display("FAIL %s load_entry: cpu_reset=%b busy=%b done=%b s_ready=%b want 1 1 0 1",
                 tag, cpu_reset, busy, done, s_ready);
      else passed++;
    end
    i = 0; k = 0; guard = 0;
    while (i < len && guard < 2000) begin
      if (use_pat) s_valid = pat[k % 16];
      else         s_valid = ($urandom_range(99) < pct);
      s_data = tx_words[i];
      if (s_valid && s_ready === 1'b1) i++;
      k++; guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    total++;
    if (i != len) $display("FAIL %s load_timeout: accepted %0d want %0d", tag, i, len);
    else passed++;
    total++;
    if (s_ready !== 1'b0 || cpu_reset !== 1'b0 || fetch_enable !== 1'b0 ||
        reg_write_enable !== 1'b0 || busy !== 1'b1 || base_pc !== base)
      $display("FAIL %s start_state: s_ready=%b cpu_reset=%b fetch=%b rwe=%b busy=%b base_pc=%h want 0 0 0 0 1 %h",
               tag, s_ready, cpu_reset, fetch_enable, reg_write_enable, busy, base_pc, base);
    else passed++;
    @(negedge clk);
    n = 0; bad_track = 0; guard = 0;
    while (fetch_enable === 1'b1 && guard < runc + 50) begin
      n++; guard++;
      if (reg_write_enable !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
        bad_track++;
      if (poke && n == 2) begin
        start = 1'b1; base_addr = ~base; prog_len = LEN_W'(1);
      end else begin
        start = 1'b0; base_addr = base;
      end
      @(negedge clk);
    end
    start = 1'b0; base_addr = base;
    total++;
    if (n != runc) $display("FAIL %s run_len: got %0d cycles want %0d", tag, n, runc);
    else passed++;
    total++;
    if (bad_track != 0) $display("FAIL %s run_outputs: %0d bad cycles want 0", tag, bad_track);
    else passed++;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || fetch_enable !== 1'b0 || reg_write_enable !== 1'b0 ||
        cpu_reset !== 1'b0 || base_pc !== base)
      $display("FAIL %s halt_state: done=%b busy=%b fetch=%b rwe=%b cpu_reset=%b base_pc=%h want 1 0 0 0 0 %h",
               tag, done, busy, fetch_enable, reg_write_enable, cpu_reset, base_pc, base);
    else passed++;
    total++;
    if (wa_q.size() != len) $display("FAIL %s write_count: got %0d want %0d", tag, wa_q.size(), len);
    else passed++;
    err = 0;
    nchk = (wa_q.size() < len) ? wa_q.size() : len;
    for (int j = 0; j < int'(nchk); j++) begin
      ea = base + ADDR_W'(j) * ADDR_W'(4);
      if (wa_q[j] !== ea || wd_q[j] !== tx_words[j]) err++;
      if (!use_pat && pct >= 100 && wc_q[j] != wc_q[0] + j) err++;
    end
    total++;
    if (err != 0 || nchk != len)
      $display("FAIL %s write_contents: %0d bad entries of %0d want 0", tag, err, len);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); else passed++;
    total++;
    if (load_enable !== 1'b0 || fetch_enable !== 1'b0 || reg_write_enable !== 1'b0)
      $display("FAIL reset_enables: load=%b fetch=%b rwe=%b want 0 0 0",
               load_enable, fetch_enable, reg_write_enable);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL reset_status: busy=%b done=%b s_ready=%b want 0 0 0", busy, done, s_ready);
    else passed++;
    total++;
    if (base_pc !== '0) $display("FAIL reset_base_pc: got %h want 0", base_pc); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_load_run();
    tx_words.delete();
    tx_words.push_back(32'h00500093);
    tx_words.push_back(32'h00A00113);
    tx_words.push_back(32'h002081B3);
    run_program(32'h0, 32'd10, 16'h0, 1'b0, 100, 1'b0, "load_run");
  endtask

  task automatic test_stall();
    tx_words.delete();
    for (int j = 0; j < 3; j++) tx_words.push_back($urandom);
    run_program(32'hFFFFFFFC, 32'd4, 16'hFFF9, 1'b1, 0, 1'b0, "stall_wrap");
  endtask

  task automatic test_zero_len();
    logic [ADDR_W-1:0] b;
    int n;
    b = $urandom;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    @(negedge clk);
    start = 1'b1; prog_len = '0; base_addr = b; run_cycles = '0;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_data = $urandom;
    total++;
    if (busy !== 1'b1 || cpu_reset !== 1'b0 || fetch_enable !== 1'b0 || s_ready !== 1'b0 || base_pc !== b)
      $display("FAIL zero_len_start: busy=%b cpu_reset=%b fetch=%b s_ready=%b base_pc=%h want 1 0 0 0 %h",
               busy, cpu_reset, fetch_enable, s_ready, base_pc, b);
    else passed++;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (fetch_enable === 1'b1 && reg_write_enable === 1'b1 && done === 1'b0) n++;
    end
    total++;
    if (n != 25) $display("FAIL zero_len_run: fetch cycles %0d want 25", n); else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    total++;
    if (cpu_reset !== 1'b1 || fetch_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_len_abort: cpu_reset=%b fetch=%b busy=%b done=%b want 1 0 0 0",
               cpu_reset, fetch_enable, busy, done);
    else passed++;
    total++;
    if (wa_q.size() != 0) $display("FAIL zero_len_writes: got %0d want 0", wa_q.size()); else passed++;
  endtask

  task automatic test_abort_load();
    logic [DATA_W-1:0] w[4];
    for (int j = 0; j < 4; j++) w[j] = $urandom;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    @(negedge clk);
    start = 1'b1; prog_len = LEN_W'(4); base_addr = 32'h1000; run_cycles = 32'd5;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_data = w[0];
    @(negedge clk);
    // start while loading must be ignored
    s_data = w[1]; start = 1'b1; base_addr = 32'h2000; prog_len = LEN_W'(1);
    @(negedge clk);
    start = 1'b0; base_addr = 32'h1000;
    s_data = w[2]; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    total++;
    if (cpu_reset !== 1'b1 || s_ready !== 1'b0 || load_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_state: cpu_reset=%b s_ready=%b load=%b busy=%b done=%b want 1 0 0 0 0",
               cpu_reset, s_ready, load_enable, busy, done);
    else passed++;
    total++;
    if (base_pc !== 32'h1000) $display("FAIL abort_base_pc: got %h want 00001000", base_pc); else passed++;
    @(negedge clk);
    total++;
    if (wa_q.size() != 2) $display("FAIL abort_write_count: got %0d want 2", wa_q.size());
    else passed++;
    if (wa_q.size() == 2) begin
      total++;
      if (wa_q[1] !== 32'h1004 || wd_q[1] !== w[1] || wd_q[0] !== w[0])
        $display("FAIL abort_writes: addr1=%h data0=%h data1=%h want 00001004 %h %h",
                 wa_q[1], wd_q[0], wd_q[1], w[0], w[1]);
      else passed++;
    end
  endtask

  task automatic test_reset_run();
    @(negedge clk);
    start = 1'b1; prog_len = LEN_W'(1); base_addr = 32'h40; run_cycles = '0;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = $urandom;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (fetch_enable !== 1'b1) $display("FAIL reset_run_pre: fetch=%b want 1", fetch_enable); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1 || fetch_enable !== 1'b0 || reg_write_enable !== 1'b0 || load_enable !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 || base_pc !== '0)
      $display("FAIL reset_run_post: cpu_reset=%b fetch=%b rwe=%b load=%b busy=%b done=%b s_ready=%b base_pc=%h want 1 0 0 0 0 0 0 0",
               cpu_reset, fetch_enable, reg_write_enable, load_enable, busy, done, s_ready, base_pc);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int unsigned len;
      len = $urandom_range(6, 0);
      tx_words.delete();
      for (int j = 0; j < int'(len); j++) tx_words.push_back($urandom);
      run_program($urandom, CNT_W'($urandom_range(12, 1)), 16'h0, 1'b0,
                  int'($urandom_range(100, 30)), 1'($urandom_range(1, 0)), "random");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; prog_len = '0; base_addr = '0;
    run_cycles = '0; s_valid = 1'b0; s_data = '0;
    test_reset();
    test_load_run();
    test_stall();
    test_zero_len();
    test_abort_load();
    test_reset_run();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
